// File: rtl/oric_bus_ctrl.sv
// Oric bus controller: reset sequencer, prioritised CPU read-data mux with
// open-bus retention, and per-window bus conflict monitoring.
module oric_bus_ctrl #(
    parameter int unsigned NSRC     = 6,
    parameter int unsigned DW       = 8,
    parameter int unsigned RST_HOLD = 255
) (
    input  logic                           i_clk_in,
    input  logic                           i_reset,
    input  logic                           i_pll_locked,
    input  logic                           i_ext_rstn,
    input  logic                           i_phi2_en,
    input  logic                           i_phi2,
    input  logic                           i_cpu_rw,
    input  logic [NSRC-1:0]                i_src_sel,
    input  logic [NSRC*DW-1:0]             i_src_data,
    input  logic                           i_conflict_clr,
    output logic [DW-1:0]                  o_cpu_di,
    output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] o_last_src,
    output logic                           o_host_resetn,
    output logic [1:0]                     o_rst_state,
    output logic                           o_bus_conflict,
    output logic [7:0]                     o_conflict_cnt
);

    localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_hold_cnt;
    logic [CW-1:0]   w_hold_cnt_nxt;
    logic            w_clk_ok;

    logic            r_host_resetn;
    logic [DW-1:0]   r_cpu_di;
    logic [SW-1:0]   r_last_src;
    logic            r_bus_conflict;
    logic [7:0]      r_conflict_cnt;
    logic            r_win_counted;

    logic            w_qual;
    logic            w_hit;
    logic            w_multi;
    logic            w_count;
    logic [SW-1:0]   w_sel_idx;
    logic [DW-1:0]   w_sel_data;

    assign w_clk_ok = i_pll_locked & i_ext_rstn;

    // Sequencer next-state; loss of lock or external reset overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_clk_ok) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (!w_clk_ok) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (i_phi2_en) begin
                    w_hold_cnt_nxt = r_hold_cnt + CW'(1);
                    if (r_hold_cnt == CW'(RST_HOLD - 1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!w_clk_ok) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge i_clk_in) begin
        if (i_reset) begin
            r_state       <= ST_WAIT_LOCK;
            r_hold_cnt    <= '0;
            r_host_resetn <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_host_resetn <= (r_state == ST_RUN);
        end
    end

    // Lowest-index select wins; the loop runs high-to-low so low indices overwrite
    always_comb begin
        w_sel_idx  = '0;
        w_sel_data = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (i_src_sel[i]) begin
                w_sel_idx  = SW'(i);
                w_sel_data = i_src_data[i*DW +: DW];
            end
        end
    end

    assign w_qual  = i_cpu_rw & i_phi2 & r_host_resetn;
    assign w_hit   = |i_src_sel;
    assign w_multi = |(i_src_sel & (i_src_sel - NSRC'(1)));
    // r_win_counted is only ever set inside a window, so it self-clears between windows
    assign w_count = w_qual & w_multi & ~r_win_counted;

    always_ff @(posedge i_clk_in) begin
        if (i_reset) begin
            r_cpu_di       <= '1;
            r_last_src     <= '0;
            r_bus_conflict <= 1'b0;
            r_conflict_cnt <= '0;
            r_win_counted  <= 1'b0;
        end else begin
            if (w_qual && w_hit) begin
                r_cpu_di   <= w_sel_data;
                r_last_src <= w_sel_idx;
            end
            r_win_counted <= w_qual & (r_win_counted | w_multi);
            if (i_conflict_clr) begin
                r_bus_conflict <= w_count;
                r_conflict_cnt <= w_count ? 8'd1 : 8'd0;
            end else if (w_count) begin
                r_bus_conflict <= 1'b1;
                if (r_conflict_cnt != 8'hFF) begin
                    r_conflict_cnt <= r_conflict_cnt + 8'd1;
                end
            end
        end
    end

    assign o_cpu_di       = r_cpu_di;
    assign o_last_src     = r_last_src;
    assign o_host_resetn  = r_host_resetn;
    assign o_rst_state    = r_state;
    assign o_bus_conflict = r_bus_conflict;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_oric_bus_ctrl.sv
// Directed self-checking bench for oric_bus_ctrl (RST_HOLD shortened to 4).
module tb_oric_bus_ctrl;

    localparam int unsigned NSRC = 6;
    localparam int unsigned DW   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pll_locked = 1'b0;
    logic              ext_rstn = 1'b1;
    logic              phi2_en = 1'b0;
    logic              phi2 = 1'b0;
    logic              cpu_rw = 1'b0;
    logic [NSRC-1:0]   src_sel = '0;
    logic [NSRC*DW-1:0] src_data = '0;
    logic              conflict_clr = 1'b0;
    logic [DW-1:0]     cpu_di;
    logic [2:0]        last_src;
    logic              host_resetn;
    logic [1:0]        rst_state;
    logic              bus_conflict;
    logic [7:0]        conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    oric_bus_ctrl #(.NSRC(NSRC), .DW(DW), .RST_HOLD(4)) dut (
        .i_clk_in       (clk),
        .i_reset        (reset),
        .i_pll_locked   (pll_locked),
        .i_ext_rstn     (ext_rstn),
        .i_phi2_en      (phi2_en),
        .i_phi2         (phi2),
        .i_cpu_rw       (cpu_rw),
        .i_src_sel      (src_sel),
        .i_src_data     (src_data),
        .i_conflict_clr (conflict_clr),
        .o_cpu_di       (cpu_di),
        .o_last_src     (last_src),
        .o_host_resetn  (host_resetn),
        .o_rst_state    (rst_state),
        .o_bus_conflict (bus_conflict),
        .o_conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en();
        phi2_en = 1'b1;
        tick();
        phi2_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reset, then walk WAIT_LOCK -> HOLD -> RUN with host reset released
    task automatic bring_up();
        cpu_rw = 1'b0; phi2 = 1'b0; src_sel = '0;
        pll_locked = 1'b0; ext_rstn = 1'b1;
        do_reset();
        pll_locked = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) pulse_en();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_locked = 1'b1;
        tick(); tick();
        n_cmp++; if (rst_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", rst_state); end
        n_cmp++; if (host_resetn !== 1'b0) begin n_err++; $display("FAIL reset_hostn got %b want 0", host_resetn); end
        n_cmp++; if (cpu_di !== 8'hFF) begin n_err++; $display("FAIL reset_cpu_di got %h want ff", cpu_di); end
        n_cmp++; if (last_src !== 3'd0) begin n_err++; $display("FAIL reset_last_src got %0d want 0", last_src); end
        n_cmp++; if (bus_conflict !== 1'b0 || conflict_cnt !== 8'd0) begin n_err++; $display("FAIL reset_conflict got %b/%0d want 0/0", bus_conflict, conflict_cnt); end
    endtask

    task automatic test_sequencer();
        reset = 1'b0;
        tick();
        n_cmp++; if (rst_state !== 2'd1) begin n_err++; $display("FAIL seq_enter_hold got %0d want 1", rst_state); end
        tick(); tick();
        n_cmp++; if (rst_state !== 2'd1) begin n_err++; $display("FAIL seq_idle_hold got %0d want 1", rst_state); end
        for (int i = 0; i < 3; i++) pulse_en();
        n_cmp++; if (rst_state !== 2'd1) begin n_err++; $display("FAIL seq_after3 got %0d want 1", rst_state); end
        pulse_en();
        n_cmp++; if (rst_state !== 2'd2 || host_resetn !== 1'b0) begin n_err++; $display("FAIL seq_run got %0d/%b want 2/0", rst_state, host_resetn); end
        tick();
        n_cmp++; if (host_resetn !== 1'b1) begin n_err++; $display("FAIL seq_hostn got %b want 1", host_resetn); end
    endtask

    task automatic test_ext_reset();
        ext_rstn = 1'b0;
        tick();
        ext_rstn = 1'b1;
        n_cmp++; if (rst_state !== 2'd0) begin n_err++; $display("FAIL ext_wait got %0d want 0", rst_state); end
        tick();
        n_cmp++; if (rst_state !== 2'd1 || host_resetn !== 1'b0) begin n_err++; $display("FAIL ext_rehold got %0d/%b want 1/0", rst_state, host_resetn); end
        for (int i = 0; i < 3; i++) pulse_en();
        n_cmp++; if (rst_state !== 2'd1) begin n_err++; $display("FAIL ext_recount got %0d want 1", rst_state); end
        pulse_en();
        tick();
        n_cmp++; if (rst_state !== 2'd2 || host_resetn !== 1'b1) begin n_err++; $display("FAIL ext_run got %0d/%b want 2/1", rst_state, host_resetn); end
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n_cmp++; if (rst_state !== 2'd0) begin n_err++; $display("FAIL pll_loss got %0d want 0", rst_state); end
    endtask

    task automatic test_read();
        bring_up();
        src_data = {8'hC3, 8'h44, 8'h33, 8'h5A, 8'h77, 8'h11};
        cpu_rw = 1'b1; phi2 = 1'b1; src_sel = 6'b100100;
        tick();
        n_cmp++; if (cpu_di !== 8'h5A || last_src !== 3'd2) begin n_err++; $display("FAIL read_prio got %h/%0d want 5a/2", cpu_di, last_src); end
        n_cmp++; if (bus_conflict !== 1'b1 || conflict_cnt !== 8'd1) begin n_err++; $display("FAIL read_conflict got %b/%0d want 1/1", bus_conflict, conflict_cnt); end
        src_sel = '0;
        tick();
        n_cmp++; if (cpu_di !== 8'h5A || last_src !== 3'd2) begin n_err++; $display("FAIL open_bus got %h/%0d want 5a/2", cpu_di, last_src); end
        phi2 = 1'b0; src_sel = 6'b000001;
        tick();
        n_cmp++; if (cpu_di !== 8'h5A || last_src !== 3'd2) begin n_err++; $display("FAIL phi2_low got %h/%0d want 5a/2", cpu_di, last_src); end
        phi2 = 1'b1; cpu_rw = 1'b0;
        tick();
        n_cmp++; if (cpu_di !== 8'h5A) begin n_err++; $display("FAIL write_cycle got %h want 5a", cpu_di); end
        cpu_rw = 1'b1; src_sel = 6'b000010;
        tick();
        n_cmp++; if (cpu_di !== 8'h77 || last_src !== 3'd1 || conflict_cnt !== 8'd1) begin n_err++; $display("FAIL single_sel got %h/%0d/%0d want 77/1/1", cpu_di, last_src, conflict_cnt); end
    endtask

    task automatic test_back_to_back();
        phi2 = 1'b0; src_sel = '0;
        tick();
        phi2 = 1'b1; src_sel = 6'b011000;
        tick();
        n_cmp++; if (cpu_di !== 8'h33 || last_src !== 3'd3 || conflict_cnt !== 8'd2) begin n_err++; $display("FAIL win_first got %h/%0d/%0d want 33/3/2", cpu_di, last_src, conflict_cnt); end
        src_sel = 6'b110000;
        tick();
        n_cmp++; if (cpu_di !== 8'h44 || last_src !== 3'd4 || conflict_cnt !== 8'd2) begin n_err++; $display("FAIL win_repeat got %h/%0d/%0d want 44/4/2", cpu_di, last_src, conflict_cnt); end
        phi2 = 1'b0;
        tick();
        phi2 = 1'b1; src_sel = 6'b100001;
        tick();
        n_cmp++; if (cpu_di !== 8'h11 || last_src !== 3'd0 || conflict_cnt !== 8'd3) begin n_err++; $display("FAIL win_new got %h/%0d/%0d want 11/0/3", cpu_di, last_src, conflict_cnt); end
        phi2 = 1'b0; src_sel = '0;
        tick();
    endtask

    task automatic test_saturation();
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        n_cmp++; if (bus_conflict !== 1'b0 || conflict_cnt !== 8'd0) begin n_err++; $display("FAIL clr_only got %b/%0d want 0/0", bus_conflict, conflict_cnt); end
        for (int i = 0; i < 300; i++) begin
            phi2 = 1'b1; src_sel = 6'b000011;
            tick();
            phi2 = 1'b0; src_sel = '0;
            tick();
        end
        n_cmp++; if (conflict_cnt !== 8'd255 || bus_conflict !== 1'b1) begin n_err++; $display("FAIL saturate got %0d/%b want 255/1", conflict_cnt, bus_conflict); end
        phi2 = 1'b1; src_sel = 6'b000011; conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        n_cmp++; if (conflict_cnt !== 8'd1 || bus_conflict !== 1'b1) begin n_err++; $display("FAIL clr_coincident got %0d/%b want 1/1", conflict_cnt, bus_conflict); end
    endtask

    task automatic test_reset_mid();
        src_sel = 6'b000110;
        reset = 1'b1;
        tick();
        n_cmp++; if (cpu_di !== 8'hFF || last_src !== 3'd0 || conflict_cnt !== 8'd0 || bus_conflict !== 1'b0) begin n_err++; $display("FAIL reset_mid_read got %h/%0d/%0d/%b want ff/0/0/0", cpu_di, last_src, conflict_cnt, bus_conflict); end
        n_cmp++; if (rst_state !== 2'd0 || host_resetn !== 1'b0) begin n_err++; $display("FAIL reset_mid_state got %0d/%b want 0/0", rst_state, host_resetn); end
        reset = 1'b0;
        tick();
        pulse_en(); pulse_en();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) pulse_en();
        n_cmp++; if (rst_state !== 2'd1) begin n_err++; $display("FAIL reset_mid_hold got %0d want 1", rst_state); end
        n_cmp++; if (cpu_di !== 8'hFF) begin n_err++; $display("FAIL read_in_hold got %h want ff", cpu_di); end
    endtask

    initial begin
        test_reset();
        test_sequencer();
        test_ext_reset();
        test_read();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
